// File: rtl/calc_pkg.sv
// Shared types for the calc token-stream calculator and its request scheduler.
package calc_pkg;

    localparam int unsigned CALC_W = 16;

    typedef enum logic [1:0] {
        OpMul = 2'd0,
        OpAdd = 2'd1,
        OpSqr = 2'd2,
        OpInc = 2'd3
    } calc_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StSendA,
        StSendOp,
        StSendB,
        StWait,
        StResp
    } sched_state_e;

endpackage

// File: rtl/calc_rr_arb.sv
// Combinational round-robin pick: search starts one past the last winner.
module calc_rr_arb #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IdW-1:0]   gnt_idx,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = IdW'(idx);
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/calc_sched.sv
// Serializes one requester operation at a time into calc's A/op/B token stream
// and returns calc's registered result tagged with the requester index.
module calc_sched
    import calc_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = CALC_W,
    localparam int unsigned IdW  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [W*N_REQ-1:0] req_a,
    input  logic [W*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    output logic [IdW-1:0]     rsp_id,
    output logic [W-1:0]       rsp_data,
    output logic               calc_valid,
    output logic [W-1:0]       calc_data,
    input  logic [W-1:0]       calc_result,
    output logic               busy
);

    sched_state_e state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] id_q, id_d;
    calc_op_e       op_q, op_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           calc_valid_q, calc_valid_d;
    logic [W-1:0]   calc_data_q, calc_data_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IdW-1:0]   arb_idx;
    logic             arb_any;
    int unsigned      sel;

    calc_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        op_d         = op_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        calc_valid_d = 1'b0;
        calc_data_d  = calc_data_q;
        req_ready    = '0;
        sel          = 32'(arb_idx);

        unique case (state_q)
            StIdle: begin
                // Gated by rst so no requester sees a grant that reset discards.
                if (arb_any && !rst) begin
                    req_ready    = arb_gnt;
                    ptr_d        = arb_idx;
                    id_d         = arb_idx;
                    op_d         = calc_op_e'(req_op[2*sel +: 2]);
                    b_d          = req_b[W*sel +: W];
                    calc_valid_d = 1'b1;
                    calc_data_d  = req_a[W*sel +: W];
                    state_d      = StSendA;
                end
            end
            StSendA: begin
                calc_valid_d = 1'b1;
                calc_data_d  = {{(W-2){1'b0}}, op_q};
                state_d      = StSendOp;
            end
            StSendOp: begin
                if (op_q inside {OpMul, OpAdd}) begin
                    calc_valid_d = 1'b1;
                    calc_data_d  = b_q;
                    state_d      = StSendB;
                end else begin
                    state_d = StWait;
                end
            end
            StSendB: begin
                state_d = StWait;
            end
            StWait: begin
                rsp_data_d = calc_result;
                state_d    = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= IdW'(N_REQ - 1);
            id_q         <= '0;
            op_q         <= OpMul;
            b_q          <= '0;
            rsp_data_q   <= '0;
            calc_valid_q <= 1'b0;
            calc_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
            calc_valid_q <= calc_valid_d;
            calc_data_q  <= calc_data_d;
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_data   = rsp_data_q;
    assign calc_valid = calc_valid_q;
    assign calc_data  = calc_data_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_calc_sched.sv
// Directed bench for calc_sched with a behavioural calc model on the token port.
module tb_calc_sched;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           calc_valid;
    logic [W-1:0]   calc_data;
    logic [W-1:0]   calc_result;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    calc_sched #(
        .N_REQ (N),
        .W     (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .calc_valid  (calc_valid),
        .calc_data   (calc_data),
        .calc_result (calc_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // calc model: A token, op token, optional B token; result registered on the last token.
    logic [1:0]   cm_st;
    logic [W-1:0] cm_a;
    logic [1:0]   cm_op;
    always @(posedge clk) begin
        if (rst) begin
            cm_st       <= 2'd0;
            cm_a        <= '0;
            cm_op       <= 2'd0;
            calc_result <= '0;
        end else if (calc_valid) begin
            case (cm_st)
                2'd0: begin
                    cm_a  <= calc_data;
                    cm_st <= 2'd1;
                end
                2'd1: begin
                    cm_op <= calc_data[1:0];
                    if (calc_data[1:0] < 2'd2) begin
                        cm_st <= 2'd2;
                    end else begin
                        cm_st       <= 2'd0;
                        calc_result <= (calc_data[1:0] == 2'd2) ? cm_a * cm_a : cm_a + 16'd1;
                    end
                end
                default: begin
                    cm_st       <= 2'd0;
                    calc_result <= (cm_op == 2'd0) ? cm_a * calc_data : cm_a + calc_data;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[2*id +: 2] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
        req_valid[id]     = 1'b1;
    endtask

    // Entered in the grant cycle; returns #1 after the edge back into idle.
    task automatic expect_stream(input int id, input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] res,
                                 input bit hold);
        check("grant", 32'(req_ready), 32'(1 << id));
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        if (!hold) begin
            req_valid[id]    = 1'b0;
            req_a[W*id +: W] = 16'h5a5a;
            req_b[W*id +: W] = 16'ha5a5;
        end
        check("tokA_valid", 32'(calc_valid), 32'd1);
        check("tokA_data", 32'(calc_data), 32'(a));
        check("no_grant_busy", 32'(req_ready), 32'd0);
        tick();
        check("tokOp_valid", 32'(calc_valid), 32'd1);
        check("tokOp_data", 32'(calc_data), 32'(op));
        if (op < 2'd2) begin
            tick();
            check("tokB_valid", 32'(calc_valid), 32'd1);
            check("tokB_data", 32'(calc_data), 32'(b));
        end
        tick();
        check("wait_valid", 32'(calc_valid), 32'd0);
        check("wait_rsp", 32'(rsp_valid), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(id));
        check("rsp_data", 32'(rsp_data), 32'(res));
        tick();
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("back_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input int id, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res);
        set_req(id, op, a, b);
        #1;
        expect_stream(id, op, a, b, res, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_calc_valid", 32'(calc_valid), 32'd0);
        check("rst_calc_data", 32'(calc_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        run_op(0, 2'd1, 16'd5, 16'd7, 16'd12);
        run_op(2, 2'd2, 16'd300, 16'hbeef, 16'd24464);
        run_op(1, 2'd3, 16'hffff, 16'd0, 16'h0000);
        run_op(3, 2'd0, 16'h0100, 16'h0100, 16'h0000);

        // All four held through reset: requester 0 must win first, then rotate.
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 2'd1, 16'(1000 + i), 16'(7 * i + 1));
        end
        tick();
        check("rst_held_ready", 32'(req_ready), 32'd0);
        check("rst_held_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        expect_stream(0, 2'd1, 16'd1000, 16'd1, 16'd1001, 1'b1);
        expect_stream(1, 2'd1, 16'd1001, 16'd8, 16'd1009, 1'b1);
        expect_stream(2, 2'd1, 16'd1002, 16'd15, 16'd1017, 1'b1);
        expect_stream(3, 2'd1, 16'd1003, 16'd22, 16'd1025, 1'b1);
        expect_stream(0, 2'd1, 16'd1000, 16'd1, 16'd1001, 1'b1);
        req_valid = '0;

        // Reset in the middle of a MUL stream drops it; requester 0 is regranted.
        set_req(0, 2'd0, 16'd3, 16'd5);
        #1;
        check("mul_grant", 32'(req_ready), 32'd1);
        tick();
        check("mul_tokA", 32'(calc_data), 32'd3);
        tick();
        check("mul_tokOp", 32'(calc_data), 32'd0);
        tick();
        check("mul_tokB", 32'(calc_data), 32'd5);
        rst = 1'b1;
        tick();
        check("abort_calc_valid", 32'(calc_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        expect_stream(0, 2'd0, 16'd3, 16'd5, 16'd15, 1'b0);

        // req0 waits behind req1 and updates A before its own grant.
        set_req(0, 2'd1, 16'd9, 16'd1);
        set_req(1, 2'd3, 16'd7, 16'd0);
        #1;
        expect_stream(1, 2'd3, 16'd7, 16'd0, 16'd8, 1'b0);
        req_a[15:0] = 16'd4;
        #1;
        expect_stream(0, 2'd1, 16'd4, 16'd1, 16'd5, 1'b0);

        // A request raised and withdrawn while busy is never granted.
        set_req(1, 2'd3, 16'd1, 16'd0);
        #1;
        check("wd_grant1", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        check("wd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wd_rsp_data", 32'(rsp_data), 32'd2);
        tick();
        check("wd_no_grant", 32'(req_ready), 32'd0);
        check("wd_idle", 32'(busy), 32'd0);
        tick();
        check("wd_still_idle", 32'(busy), 32'd0);
        check("wd_no_token", 32'(calc_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
